// File: rtl/cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_scheduler_pkg
// Description : Shared definitions for the command scheduler. Holds the
//               dispatcher state encoding, the queue-entry field layout and
//               the default parameter values.
//               Entry layout, LSB to MSB:
//                   [DATA_BIT-1:0]            output pattern
//                   [2*DATA_BIT-1:DATA_BIT]   frequency pattern
//                   [2*DATA_BIT]              mode
//                   [2*DATA_BIT+4:2*DATA_BIT+1] channel select
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam int DEF_DATA_BIT     = 32;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_LOAD_TIMEOUT = 8;

    localparam int SEL_W  = 4;
    localparam int MODE_W = 1;

    // Width of one queued command for a given pattern width.
    function automatic int entry_w(input int data_bit);
        return 2 * data_bit + MODE_W + SEL_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Single-clock first-word-fall-through command queue with a
//               registered occupancy count and registered full/empty flags.
//               Pushes while full and pops while empty are ignored.
// Ports       : clk, rst_n     clock, asynchronous active-low reset
//               i_push/i_data  write request and entry
//               i_pop          consume the head entry
//               o_data         head entry (valid while o_empty is low)
//               o_full/o_empty registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             w_push, w_pop;

    assign w_push = i_push && !full_q;
    assign w_pop  = i_pop && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule
`default_nettype wire

// File: rtl/cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cmd_scheduler
// Description : Accepts decoded commands, routes stops straight to the target
//               channel, queues starts and dispatches them in strict FIFO
//               order to idle serial-out channels with a bounded wait for the
//               channel's busy acknowledge.
// Ports       : clk, rst_n                       clock, async active-low reset
//               i_done_tick + command fields      decoded command (one cycle)
//               i_ch_busy                         per-channel busy status
//               o_ch_load / o_ch_stop             one-hot one-cycle strobes
//               o_output_pattern/o_freq_pattern/o_mode  last dispatched command
//               o_fifo_full, o_drop_tick, o_err_tick    status
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_scheduler
    import cmd_scheduler_pkg::*;
#(
    parameter int DATA_BIT     = DEF_DATA_BIT,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_done_tick,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [SEL_W-1:0]    i_sel_out,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [NUM_CH-1:0]   i_ch_busy,
    output logic [NUM_CH-1:0]   o_ch_load,
    output logic [NUM_CH-1:0]   o_ch_stop,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_mode,
    output logic                o_fifo_full,
    output logic                o_drop_tick,
    output logic                o_err_tick
);

    localparam int               EW         = entry_w(DATA_BIT);
    localparam int               CW         = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [SEL_W:0]   NUM_CH_EXT = NUM_CH[SEL_W:0];

    logic                w_sel_valid, w_push_req, w_pop;
    logic                w_fifo_full, w_fifo_empty, w_head_busy, w_cur_busy;
    logic [EW-1:0]       w_push_data, w_head;
    logic [SEL_W-1:0]    w_head_sel;
    logic                w_head_mode;
    logic [DATA_BIT-1:0] w_head_pat, w_head_freq;
    logic [NUM_CH-1:0]   w_sel_oh, w_head_oh, w_cur_oh;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_BIT-1:0] pat_q, pat_d, freq_q, freq_d;
    logic                mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, drop_q;
    logic [NUM_CH-1:0]   stop_q;

    // ---------------- command intake ----------------
    assign w_sel_valid = ({1'b0, i_sel_out} < NUM_CH_EXT);
    assign w_push_req  = i_done_tick && w_sel_valid && i_start && !i_stop;
    assign w_push_data = {i_sel_out, i_mode, i_freq_pattern, i_output_pattern};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dec
        assign w_sel_oh[k]  = (i_sel_out  == SEL_W'(k));
        assign w_head_oh[k] = (w_head_sel == SEL_W'(k));
        assign w_cur_oh[k]  = (sel_q      == SEL_W'(k));
    end

    // Drop decision uses the registered full flag, so a pop in the same
    // cycle does not rescue the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= 1'b0;
            stop_q <= '0;
        end else begin
            err_q  <= i_done_tick && !w_sel_valid;
            drop_q <= w_push_req && w_fifo_full;
            stop_q <= (i_done_tick && w_sel_valid && i_stop) ? w_sel_oh : '0;
        end
    end

    cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_head_sel, w_head_mode, w_head_freq, w_head_pat} = w_head;
    assign w_head_busy = |(i_ch_busy & w_head_oh);
    assign w_cur_busy  = |(i_ch_busy & w_cur_oh);

    // ---------------- dispatcher ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            pat_q   <= '0;
            freq_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pat_q   <= pat_d;
            freq_q  <= freq_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pat_d   = pat_q;
        freq_d  = freq_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A busy head blocks everything behind it: no reordering.
                if (!w_fifo_empty && !w_head_busy) begin
                    w_pop   = 1'b1;
                    sel_d   = w_head_sel;
                    pat_d   = w_head_pat;
                    freq_d  = w_head_freq;
                    mode_d  = w_head_mode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // S_WAIT lasts at most LOAD_TIMEOUT cycles.
                if (w_cur_busy || (cnt_q == CW'(LOAD_TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_ch_load        = (state_q == S_LOAD) ? w_cur_oh : '0;
    assign o_ch_stop        = stop_q;
    assign o_output_pattern = pat_q;
    assign o_freq_pattern   = freq_q;
    assign o_mode           = mode_q;
    assign o_fifo_full      = w_fifo_full;
    assign o_drop_tick      = drop_q;
    assign o_err_tick       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_scheduler
// Description : Self-checking bench for cmd_scheduler: directed scenarios for
//               latency, queue full/drop, stop bypass, select errors, load
//               timeout and mid-dispatch reset, plus a randomized run checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_scheduler;

    localparam int DB    = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_done_tick = 1'b0;
    logic [DB-1:0] i_output_pattern = '0;
    logic [DB-1:0] i_freq_pattern = '0;
    logic [3:0]    i_sel_out = '0;
    logic          i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0;
    logic [NCH-1:0] i_ch_busy = '0;
    logic [NCH-1:0] o_ch_load, o_ch_stop;
    logic [DB-1:0]  o_output_pattern, o_freq_pattern;
    logic           o_mode, o_fifo_full, o_drop_tick, o_err_tick;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DB-1:0] pat;
        logic [DB-1:0] freq;
        logic          mode;
        int            sel;
    } ent_t;

    always #5 clk = ~clk;

    cmd_scheduler #(
        .DATA_BIT(DB), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .LOAD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_done_tick(i_done_tick),
        .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
        .i_sel_out(i_sel_out), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_ch_busy(i_ch_busy), .o_ch_load(o_ch_load), .o_ch_stop(o_ch_stop),
        .o_output_pattern(o_output_pattern), .o_freq_pattern(o_freq_pattern),
        .o_mode(o_mode), .o_fifo_full(o_fifo_full), .o_drop_tick(o_drop_tick),
        .o_err_tick(o_err_tick)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input bit st, input bit sp, input bit md, input int sel,
                             input logic [DB-1:0] pat, input logic [DB-1:0] frq);
        i_done_tick      = 1'b1;
        i_start          = st;
        i_stop           = sp;
        i_mode           = md;
        i_sel_out        = 4'(sel);
        i_output_pattern = pat;
        i_freq_pattern   = frq;
    endtask

    task automatic clear_cmd();
        i_done_tick = 1'b0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
    endtask

    task automatic send(input bit st, input bit sp, input bit md, input int sel,
                        input logic [DB-1:0] pat, input logic [DB-1:0] frq);
        drive_cmd(st, sp, md, sel, pat, frq);
        tick();
        clear_cmd();
    endtask

    task automatic wait_load(input int max, output bit found, output int waited);
        found  = 1'b0;
        waited = 0;
        while (waited < max && !found) begin
            tick();
            waited++;
            if (o_ch_load !== '0) found = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_cmd();
        i_ch_busy = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic settle();
        repeat (TO + 6) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2*DB+2*NCH+4-1:0] all;
        #12;
        all = {o_ch_load, o_ch_stop, o_output_pattern, o_freq_pattern,
               o_mode, o_fifo_full, o_drop_tick, o_err_tick};
        n_cmp++;
        if (all !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", all);
        end
        do_reset();
        all = {o_ch_load, o_ch_stop, o_output_pattern, o_freq_pattern,
               o_mode, o_fifo_full, o_drop_tick, o_err_tick};
        n_cmp++;
        if (all !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h expected 0", all);
        end
    endtask

    task automatic test_basic();
        i_ch_busy = '0;
        send(1, 0, 1, 2, 32'hA5A5A5A5, 32'h0000FFFF);
        n_cmp++;
        if (o_ch_load !== 4'b0000) begin
            n_bad++;
            $display("FAIL basic_t1_load: got %b expected 0000", o_ch_load);
        end
        tick();
        n_cmp++;
        if ({o_ch_load, o_output_pattern, o_freq_pattern, o_mode} !==
            {4'b0100, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_t2_load: got %b %h %h %b expected 0100 a5a5a5a5 0000ffff 1",
                     o_ch_load, o_output_pattern, o_freq_pattern, o_mode);
        end
        tick();
        n_cmp++;
        if ({o_ch_load, o_output_pattern, o_mode} !== {4'b0000, 32'hA5A5A5A5, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_hold: got %b %h %b expected 0000 a5a5a5a5 1",
                     o_ch_load, o_output_pattern, o_mode);
        end
        settle();
    endtask

    task automatic test_full_drop();
        bit found;
        int w;
        int extra;
        i_ch_busy = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(1, 0, 0, 0, 32'(i + 1), 32'(100 + i));
            tick();
            n_cmp++;
            if (o_drop_tick !== ((i == 4) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL drop_tick_%0d: got %b expected %b", i, o_drop_tick, (i == 4));
            end
        end
        clear_cmd();
        n_cmp++;
        if (o_fifo_full !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_full_set: got %b expected 1", o_fifo_full);
        end
        i_ch_busy = '0;
        for (int i = 0; i < 4; i++) begin
            wait_load(TO + 6, found, w);
            n_cmp++;
            if (!found || o_ch_load !== 4'b0001 || o_output_pattern !== 32'(i + 1)) begin
                n_bad++;
                $display("FAIL full_order_%0d: got found=%b load=%b pat=%h expected 0001 %h",
                         i, found, o_ch_load, o_output_pattern, 32'(i + 1));
            end
        end
        extra = 0;
        for (int k = 0; k < TO + 6; k++) begin
            tick();
            if (o_ch_load !== '0) extra++;
        end
        n_cmp++;
        if (extra != 0 || o_fifo_full !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drain: got extra=%0d full=%b expected 0 0", extra, o_fifo_full);
        end
    endtask

    task automatic test_stop();
        bit found;
        int w;
        i_ch_busy = '0;
        send(1, 0, 0, 1, 32'h11, 32'h1111);
        tick();
        n_cmp++;
        if (o_ch_load !== 4'b0010) begin
            n_bad++;
            $display("FAIL stop_first_load: got %b expected 0010", o_ch_load);
        end
        tick();
        // Dispatch now waiting; stop with start also set: stop must win.
        send(1, 1, 0, 1, 32'h99, 32'h9999);
        n_cmp++;
        if ({o_ch_stop, o_ch_load, o_output_pattern} !== {4'b0010, 4'b0000, 32'h11}) begin
            n_bad++;
            $display("FAIL stop_strobe: got stop=%b load=%b pat=%h expected 0010 0000 11",
                     o_ch_stop, o_ch_load, o_output_pattern);
        end
        tick();
        n_cmp++;
        if (o_ch_stop !== 4'b0000) begin
            n_bad++;
            $display("FAIL stop_one_cycle: got %b expected 0000", o_ch_stop);
        end
        send(1, 0, 1, 1, 32'h22, 32'h2222);
        wait_load(TO + 8, found, w);
        n_cmp++;
        if (!found || o_ch_load !== 4'b0010 || o_output_pattern !== 32'h22 || o_mode !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_then_load: got found=%b load=%b pat=%h mode=%b expected 0010 22 1",
                     found, o_ch_load, o_output_pattern, o_mode);
        end
        settle();
    endtask

    task automatic test_err();
        bit found;
        int w;
        send(1, 0, 0, 5, 32'h55, 32'h55);
        n_cmp++;
        if ({o_err_tick, o_ch_stop, o_ch_load, o_drop_tick} !== {1'b1, 4'b0, 4'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL err_sel5: got err=%b stop=%b load=%b drop=%b expected 1 0000 0000 0",
                     o_err_tick, o_ch_stop, o_ch_load, o_drop_tick);
        end
        send(0, 1, 0, 7, 32'h77, 32'h77);
        n_cmp++;
        if ({o_err_tick, o_ch_stop} !== {1'b1, 4'b0}) begin
            n_bad++;
            $display("FAIL err_stop_sel7: got err=%b stop=%b expected 1 0000", o_err_tick, o_ch_stop);
        end
        tick();
        n_cmp++;
        if (o_err_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL err_one_cycle: got %b expected 0", o_err_tick);
        end
        send(0, 0, 0, 2, 32'h33, 32'h33);
        wait_load(12, found, w);
        n_cmp++;
        if (found || o_fifo_full !== 1'b0 || o_err_tick !== 1'b0 || o_ch_stop !== '0) begin
            n_bad++;
            $display("FAIL err_no_side_effect: got load_found=%b full=%b expected 0 0", found, o_fifo_full);
        end
    endtask

    task automatic test_timeout();
        bit found;
        int w;
        int gap;
        i_ch_busy = '0;
        drive_cmd(1, 0, 0, 3, 32'hA1, 32'h1);
        tick();
        drive_cmd(1, 0, 0, 3, 32'hB2, 32'h2);
        tick();
        clear_cmd();
        n_cmp++;
        if (o_ch_load !== 4'b1000) begin
            n_bad++;
            $display("FAIL timeout_first_load: got %b expected 1000", o_ch_load);
        end
        wait_load(TO + 6, found, w);
        n_cmp++;
        if (!found || w != TO + 2 || o_output_pattern !== 32'hB2) begin
            n_bad++;
            $display("FAIL timeout_gap: got found=%b gap=%0d pat=%h expected gap %0d pat b2",
                     found, w, o_output_pattern, TO + 2);
        end
        settle();
        // Busy acknowledge ends the wait early; a busy head then blocks.
        drive_cmd(1, 0, 0, 2, 32'hC3, 32'h3);
        tick();
        drive_cmd(1, 0, 0, 2, 32'hD4, 32'h4);
        tick();
        clear_cmd();
        found = 1'b0;
        gap = 0;
        for (int k = 1; k <= TO + 6 && !found; k++) begin
            tick();
            i_ch_busy = (k <= 3) ? 4'b0100 : 4'b0000;
            if (o_ch_load !== '0) begin
                found = 1'b1;
                gap = k;
            end
        end
        i_ch_busy = '0;
        n_cmp++;
        if (!found || gap != 5 || o_output_pattern !== 32'hD4) begin
            n_bad++;
            $display("FAIL busy_ack_gap: got found=%b gap=%0d pat=%h expected gap 5 pat d4",
                     found, gap, o_output_pattern);
        end
        settle();
    endtask

    task automatic test_reset_midload();
        bit found;
        int w;
        logic [2*DB+2*NCH+4-1:0] all;
        i_ch_busy = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1, 0, 1, 2, 32'(16'hE0 + i), 32'hF);
            tick();
        end
        clear_cmd();
        i_ch_busy = '0;
        wait_load(6, found, w);
        n_cmp++;
        if (!found || o_output_pattern !== 32'hE0) begin
            n_bad++;
            $display("FAIL midload_first: got found=%b pat=%h expected e0", found, o_output_pattern);
        end
        rst_n = 1'b0;
        #1;
        all = {o_ch_load, o_ch_stop, o_output_pattern, o_freq_pattern,
               o_mode, o_fifo_full, o_drop_tick, o_err_tick};
        n_cmp++;
        if (all !== '0) begin
            n_bad++;
            $display("FAIL midload_reset_outputs: got %h expected 0", all);
        end
        tick();
        tick();
        rst_n = 1'b1;
        wait_load(20, found, w);
        n_cmp++;
        if (found || o_fifo_full !== 1'b0) begin
            n_bad++;
            $display("FAIL midload_queue_empty: got load_found=%b full=%b expected 0 0", found, o_fifo_full);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int bcnt[NCH];
        logic [NCH-1:0] busy_prev;
        logic [NCH-1:0] exp_stop;
        logic exp_err, exp_drop;
        int accepted, loads, count, sel;
        bit st, sp, md;
        logic [DB-1:0] pat, frq;
        do_reset();
        for (int k = 0; k < NCH; k++) bcnt[k] = 0;
        busy_prev = '0;
        exp_stop = '0;
        exp_err = 1'b0;
        exp_drop = 1'b0;
        accepted = 0;
        loads = 0;
        for (int c = 0; c < 700; c++) begin
            n_cmp++;
            if ({o_ch_stop, o_err_tick, o_drop_tick} !== {exp_stop, exp_err, exp_drop}) begin
                n_bad++;
                $display("FAIL rnd_ticks c=%0d: got stop=%b err=%b drop=%b expected %b %b %b",
                         c, o_ch_stop, o_err_tick, o_drop_tick, exp_stop, exp_err, exp_drop);
            end
            if (o_ch_load !== '0) begin
                loads++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_unexpected_load c=%0d: got %b expected none", c, o_ch_load);
                end else begin
                    e = q.pop_front();
                    if ({o_ch_load, o_output_pattern, o_freq_pattern, o_mode} !==
                        {4'(1 << e.sel), e.pat, e.freq, e.mode} || busy_prev[e.sel]) begin
                        n_bad++;
                        $display("FAIL rnd_load c=%0d: got %b %h %h %b busy=%b expected %b %h %h %b idle",
                                 c, o_ch_load, o_output_pattern, o_freq_pattern, o_mode, busy_prev,
                                 4'(1 << e.sel), e.pat, e.freq, e.mode);
                    end
                    bcnt[e.sel] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 8)) : 0;
                end
            end
            count = accepted - loads;
            n_cmp++;
            if (o_fifo_full !== (count == DEPTH)) begin
                n_bad++;
                $display("FAIL rnd_full c=%0d: got %b expected %b (count %0d)",
                         c, o_fifo_full, (count == DEPTH), count);
            end
            exp_stop = '0;
            exp_err = 1'b0;
            exp_drop = 1'b0;
            if (c < 500 && $urandom_range(0, 1) == 1) begin
                sel = int'($urandom_range(0, 5));
                st  = ($urandom_range(0, 3) != 0);
                sp  = ($urandom_range(0, 5) == 0);
                md  = 1'($urandom_range(0, 1));
                pat = $urandom;
                frq = $urandom;
                drive_cmd(st, sp, md, sel, pat, frq);
                if (sel >= NCH) begin
                    exp_err = 1'b1;
                end else if (sp) begin
                    exp_stop = 4'(1 << sel);
                end else if (st) begin
                    if (count == DEPTH) begin
                        exp_drop = 1'b1;
                    end else begin
                        e.pat = pat;
                        e.freq = frq;
                        e.mode = md;
                        e.sel = sel;
                        q.push_back(e);
                        accepted++;
                    end
                end
            end else begin
                clear_cmd();
            end
            for (int k = 0; k < NCH; k++) begin
                i_ch_busy[k] = (bcnt[k] > 0);
                if (bcnt[k] > 0) bcnt[k]--;
            end
            busy_prev = i_ch_busy;
            tick();
        end
        clear_cmd();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_drain: got %0d entries never loaded expected 0", q.size());
        end
        i_ch_busy = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full_drop();
        test_stop();
        test_err();
        test_timeout();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter DATA_BIT, default 32: width of output and frequency patterns.
REQ-002 Parameter NUM_CH, default 4: number of serial-out channels served; legal range 1..16.
REQ-003 Parameter FIFO_DEPTH, default 4: command queue depth, power of two.
REQ-004 Parameter LOAD_TIMEOUT, default 8: maximum cycles spent waiting for channel busy acknowledge.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_done_tick  in  1  one-cycle pulse; decoded command fields below are valid this cycle.
REQ-008 i_output_pattern  in  DATA_BIT  decoded output pattern.
REQ-009 i_freq_pattern  in  DATA_BIT  decoded frequency pattern.
REQ-010 i_sel_out  in  4  target channel index.
REQ-011 i_start, i_stop, i_mode  in  1 each  decoded command flags.
REQ-012 i_ch_busy  in  NUM_CH  per-channel busy status from the serial-out channels.
REQ-013 o_ch_load  out  NUM_CH  one-hot, one-cycle load strobe to the target channel.
REQ-014 o_ch_stop  out  NUM_CH  one-hot, one-cycle stop strobe.
REQ-015 o_output_pattern, o_freq_pattern  out  DATA_BIT  pattern of the last dispatched command.
REQ-016 o_mode  out  1  mode of the last dispatched command.
REQ-017 o_fifo_full  out  1  queue holds FIFO_DEPTH entries.
REQ-018 o_drop_tick  out  1  one-cycle pulse: start command discarded because the queue was full.
REQ-019 o_err_tick  out  1  one-cycle pulse: command discarded because i_sel_out >= NUM_CH.

Function
REQ-020 On i_done_tick with i_sel_out >= NUM_CH, the block SHALL discard the command and pulse o_err_tick at T+1.
REQ-021 On i_done_tick with i_stop=1 (valid channel), o_ch_stop[i_sel_out] SHALL pulse at T+1, bypassing the queue; i_start is ignored (stop wins).
REQ-022 On i_done_tick with i_start=1, i_stop=0, {pattern, freq, mode, sel} SHALL be pushed into the queue; the entry is visible at T+1.
REQ-023 A push while the registered count equals FIFO_DEPTH SHALL be dropped, even if a pop occurs in the same cycle, and o_drop_tick SHALL pulse at T+1.
REQ-024 A command with i_start=0 and i_stop=0 SHALL be ignored with no side effect.
REQ-025 The dispatcher FSM SHALL have states S_IDLE, S_LOAD, S_WAIT.
REQ-026 S_IDLE: if the queue is non-empty and i_ch_busy[head.sel]=0, pop head, register pattern/freq/mode outputs, go to S_LOAD; otherwise stay.
REQ-027 Strict FIFO order: a busy head channel SHALL block later entries (no reordering).
REQ-028 S_LOAD: o_ch_load[sel] SHALL be 1 for exactly this cycle, with o_output_pattern/o_freq_pattern/o_mode already valid; go to S_WAIT and clear the timeout counter.
REQ-029 S_WAIT: return to S_IDLE when i_ch_busy[sel]=1 or after LOAD_TIMEOUT cycles, whichever occurs first.
REQ-030 Best-case latency from i_done_tick (T, empty queue, idle channel) to o_ch_load SHALL be T+2.
REQ-031 A stop to the channel currently in S_LOAD/S_WAIT SHALL still pulse; the dispatch SHALL complete normally.
REQ-032 Pattern and mode outputs SHALL hold their value until the next dispatch.
REQ-033 o_fifo_full SHALL be registered and track the count after each push/pop.

Reset
REQ-034 On rst_n low, the block SHALL asynchronously empty the queue, set FSM to S_IDLE, and clear the timeout counter.
REQ-035 On rst_n low, all outputs SHALL be 0, including strobes and patterns.
REQ-036 A reset during S_LOAD or S_WAIT SHALL abandon the dispatch and produce no further strobe.

Structure
REQ-037 The shared package SHALL hold the FSM state encodings, the command-entry field layout/width (2*DATA_BIT+1+4), and default parameter constants.
REQ-038 The queue SHALL be a sub-module cmd_fifo (synchronous, single clock, registered count, full/empty).

Verification
REQ-039 Start, sel=2, pattern 0xA5A5A5A5, freq 0x0000FFFF, mode=1, channels idle -> o_ch_load=4'b0100 at T+2 with these values on the pattern outputs.
REQ-040 Five start commands to busy ch0 -> 4 queued, o_fifo_full=1, fifth yields o_drop_tick; after busy drops, 4 loads issue in order.
REQ-041 Stop, sel=1, while a ch1 dispatch is in S_WAIT -> o_ch_stop=4'b0010 at T+1; the dispatch completes.
REQ-042 sel=5 with NUM_CH=4 -> o_err_tick at T+1; no queue change; no strobes.
REQ-043 i_ch_busy never rises after a load -> FSM returns to S_IDLE exactly LOAD_TIMEOUT cycles after S_WAIT entry.
REQ-044 rst_n asserted in S_LOAD with 3 entries queued -> all outputs 0, queue empty, no load after release.
